// File: rtl/inst_fetch_unit_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared definitions for the instruction-fetch stage: Pcsrc encodings, FSM
// state encoding, instruction/opcode widths and the branch-offset helper.
// -----------------------------------------------------------------------------
package fetch_pkg;

    localparam int INST_W = 32;
    localparam int OP_W   = 6;

    // Next-PC select values driven by the control unit (2'b01 is reserved
    // and falls through to the sequential path).
    localparam logic [1:0] PCSRC_SEQ = 2'b00;
    localparam logic [1:0] PCSRC_BR  = 2'b10;
    localparam logic [1:0] PCSRC_JMP = 2'b11;

    typedef enum logic [0:0] {
        FETCH = 1'b0,
        HOLD  = 1'b1
    } fetch_state_e;

    // Word offset of a branch, sign-extended and scaled to a byte offset.
    function automatic logic [31:0] branch_offset(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/inst_fetch_unit_if.sv
// -----------------------------------------------------------------------------
// inst_fetch_unit_if
// Instruction-memory request/acknowledge bus.
//   Imem_req   : fetch request (master -> memory)
//   Imem_addr  : fetch address (master -> memory)
//   Imem_ack   : read data valid this cycle (memory -> master)
//   Imem_rdata : instruction word (memory -> master)
// -----------------------------------------------------------------------------
interface inst_fetch_unit_if;

    logic        Imem_req;
    logic [31:0] Imem_addr;
    logic        Imem_ack;
    logic [31:0] Imem_rdata;

    modport master (
        output Imem_req,
        output Imem_addr,
        input  Imem_ack,
        input  Imem_rdata
    );

    modport slave (
        input  Imem_req,
        input  Imem_addr,
        output Imem_ack,
        output Imem_rdata
    );

endinterface

// File: rtl/inst_fetch_unit_next_pc_calc.sv
// -----------------------------------------------------------------------------
// next_pc_calc
// Purely combinational next-PC selection.
//   Pc      : address of the instruction being retired
//   Inst    : that instruction word (branch immediate / jump index)
//   Pcsrc   : 00 sequential, 10 branch, 11 jump, 01 treated as sequential
//   next_pc : selected next PC (all arithmetic modulo 2^32)
// -----------------------------------------------------------------------------
module next_pc_calc
    import fetch_pkg::*;
(
    input  logic [31:0]       Pc,
    input  logic [INST_W-1:0] Inst,
    input  logic [1:0]        Pcsrc,
    output logic [31:0]       next_pc
);

    logic [31:0] pc4_s;
    logic [31:0] br_target_s;
    logic [31:0] jmp_target_s;
    logic        unused_op_s;

    // Opcode bits play no part in target computation.
    assign unused_op_s = ^Inst[31:26];

    // Candidate targets and the Pcsrc select.
    always_comb begin
        pc4_s        = Pc + 32'd4;
        br_target_s  = pc4_s + branch_offset(Inst[15:0]);
        // Jump stays inside the 256 MiB region of the sequential address.
        jmp_target_s = {pc4_s[31:28], Inst[25:0], 2'b00};
        case (Pcsrc)
            PCSRC_BR:  next_pc = br_target_s;
            PCSRC_JMP: next_pc = jmp_target_s;
            PCSRC_SEQ: next_pc = pc4_s;
            default:   next_pc = pc4_s;
        endcase
    end

endmodule

// File: rtl/inst_fetch_unit.sv
// -----------------------------------------------------------------------------
// inst_fetch_unit
// Instruction-fetch stage: holds the PC, fetches one instruction at a time
// over the imem handshake, presents it to decode and advances the PC on
// Retire according to Pcsrc.
//   Clk, Rst   : clock and synchronous active-high reset
//   imem       : instruction-memory bus (master side)
//   Pc         : address of the current instruction
//   Inst       : latched instruction word; Op/Func are slices of it
//   Inst_valid : Inst holds a fetched, not-yet-retired instruction
//   Retire     : downstream is done with Inst (honoured only in HOLD)
//   Pcsrc      : next-PC select sampled together with Retire
// -----------------------------------------------------------------------------
module inst_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                Clk,
    input  logic                Rst,
    inst_fetch_unit_if.master   imem,
    output logic [31:0]         Pc,
    output logic [INST_W-1:0]   Inst,
    output logic [OP_W-1:0]     Op,
    output logic [5:0]          Func,
    output logic                Inst_valid,
    input  logic                Retire,
    input  logic [1:0]          Pcsrc
);

    fetch_state_e      state_q, state_d;
    logic [31:0]       pc_q, pc_d;
    logic [INST_W-1:0] inst_q, inst_d;
    logic              valid_q, valid_d;
    logic [31:0]       next_pc_s;
    logic              req_s;
    logic              fetch_done_s;
    logic              retire_s;

    next_pc_calc u_next_pc_calc (
        .Pc      (pc_q),
        .Inst    (inst_q),
        .Pcsrc   (Pcsrc),
        .next_pc (next_pc_s)
    );

    // FSM state register.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH: begin
                if (fetch_done_s) begin
                    state_d = HOLD;
                end else begin
                    state_d = FETCH;
                end
            end
            HOLD: begin
                if (retire_s) begin
                    state_d = FETCH;
                end else begin
                    state_d = HOLD;
                end
            end
            default: state_d = FETCH;
        endcase
    end

    // FSM outputs: memory request and the two accept strobes. Ack outside a
    // live request and Retire without a valid instruction are dropped here.
    always_comb begin
        req_s        = 1'b0;
        fetch_done_s = 1'b0;
        retire_s     = 1'b0;
        case (state_q)
            FETCH: begin
                req_s        = ~Rst;
                fetch_done_s = req_s & imem.Imem_ack;
            end
            HOLD: begin
                retire_s = valid_q & Retire;
            end
            default: begin
                req_s        = 1'b0;
                fetch_done_s = 1'b0;
                retire_s     = 1'b0;
            end
        endcase
    end

    // Datapath next-state: capture on ack, advance PC on retire.
    always_comb begin
        pc_d    = pc_q;
        inst_d  = inst_q;
        valid_d = valid_q;
        if (fetch_done_s) begin
            inst_d  = imem.Imem_rdata;
            valid_d = 1'b1;
        end else if (retire_s) begin
            pc_d    = next_pc_s;
            valid_d = 1'b0;
        end else begin
            pc_d    = pc_q;
            inst_d  = inst_q;
            valid_d = valid_q;
        end
    end

    // PC, instruction and valid registers.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            pc_q    <= RESET_PC;
            inst_q  <= {INST_W{1'b0}};
            valid_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            inst_q  <= inst_d;
            valid_q <= valid_d;
        end
    end

    assign imem.Imem_req  = req_s;
    assign imem.Imem_addr = pc_q;
    assign Pc             = pc_q;
    assign Inst           = inst_q;
    assign Op             = inst_q[31:26];
    assign Func           = inst_q[5:0];
    assign Inst_valid     = valid_q;

endmodule

// File: doc/inst_fetch_unit.md
Name: inst_fetch_unit

Overview:
- Instruction-fetch stage that sits directly upstream of the control unit.
- Holds the PC and fetches each instruction from instruction memory over a request/acknowledge handshake.
- Presents the instruction, including its Op and Func fields, to the decode/control logic.
- Retires each instruction on a Retire strobe and updates the PC from the control unit's Pcsrc decision: sequential, taken branch, or jump.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word-aligned.

Ports:
- Clk  input  1  system clock; all state updates on the rising edge.
- Rst  input  1  synchronous, active-high reset.
- Imem_req  output  1  fetch request to instruction memory.
- Imem_addr  output  32  fetch address; always equals Pc.
- Imem_ack  input  1  memory has valid data on Imem_rdata this cycle.
- Imem_rdata  input  32  instruction word from memory.
- Pc  output  32  address of the current instruction.
- Inst  output  32  latched instruction word.
- Op  output  6  Inst[31:26], feeds the control unit.
- Func  output  6  Inst[5:0], feeds the control unit.
- Inst_valid  output  1  Inst holds a fetched, not-yet-retired instruction.
- Retire  input  1  downstream has finished the current instruction; sampled only when Inst_valid=1.
- Pcsrc  input  2  next-PC select from the control unit, sampled with Retire:
  - 00: PC+4
  - 10: branch target
  - 11: jump target
  - 01: reserved, treated as PC+4.

Behaviour:
- Reset values (Rst=1 at a rising edge): Pc=RESET_PC, Inst=0, Inst_valid=0, state=FETCH. Imem_req is forced 0 in any cycle where Rst=1.
- Reset is synchronous. If Rst is asserted mid-operation (in FETCH waiting on ack, or in HOLD), any in-flight ack or Retire in that cycle is ignored.
- FSM has two states, FETCH and HOLD.
- FETCH:
  - Imem_req=1 and Imem_addr=Pc, held stable until ack.
  - On Imem_ack=1: Inst<=Imem_rdata, Inst_valid<=1, go to HOLD.
  - Otherwise stay in FETCH; wait states are unbounded.
- HOLD:
  - Imem_req=0; Inst, Op, Func and Pc are stable.
  - On Retire=1: Pc<=next_pc, Inst_valid<=0, go to FETCH.
  - Otherwise stay in HOLD.
- Ignored inputs: Imem_ack while Imem_req=0, and Retire while Inst_valid=0. Neither may change any state.
- Throughput: at best one instruction every 2 cycles (ack in the first FETCH cycle, Retire in the first HOLD cycle).
- Latency: ack edge -> Inst_valid=1 on the next cycle. Retire edge -> new Imem_req on the next cycle.
- next_pc, computed from Pc and Inst; all arithmetic is 32-bit modulo 2^32:
  - pc4 = Pc + 4. 32'hFFFF_FFFC wraps to 0.
  - Branch target = pc4 + ({{14{Inst[15]}}, Inst[15:0], 2'b00}). Negative offsets are allowed; an offset of -1 targets Pc itself.
  - Jump target = {pc4[31:28], Inst[25:0], 2'b00}.
- Branch condition (Z for beq/bne) is already resolved into Pcsrc by the control unit. This block does no condition evaluation.
- Op and Func are combinational slices of Inst, so both are 0 while Inst is 0 after reset.
- Pc bits [1:0] are always 0, because every source is word-aligned.

Decomposition:
- Shared package fetch_pkg:
  - PCSRC_SEQ=2'b00, PCSRC_BR=2'b10, PCSRC_JMP=2'b11
  - FSM state encoding FETCH/HOLD
  - INST_W=32, OP_W=6
- One natural sub-module: next_pc_calc, purely combinational. Inputs Pc, Inst, Pcsrc; output next_pc. It is instantiated once and verified standalone with exhaustive Pcsrc and edge-case offsets.
- The FSM, PC register and instruction register live in the top level.

Test Plan:
- Reset and sequential fetch: RESET_PC=0, Rst for 2 cycles, then a memory returning ack in the same cycle, Retire each HOLD cycle with Pcsrc=00 -> Imem_addr sequence 0x0, 0x4, 0x8, 0xC; Inst_valid toggles 1/0; Op and Func match the words returned.
- Taken branch backward: at Pc=0x40, Inst=0x1000_FFFF, Retire with Pcsrc=10 -> next Imem_addr=0x40 (branch to self). With Inst[15:0]=0x0003 -> next Imem_addr=0x50.
- Jump: at Pc=0x1000_0010, Inst=0x0800_0040, Retire with Pcsrc=11 -> Imem_addr=0x1000_0100. Reserved Pcsrc=01 -> Imem_addr=0x1000_0014.
- Wait states and spurious strobes:
  - Imem_ack delayed 3 cycles -> Imem_req and Imem_addr held stable for all 4 cycles and Inst_valid stays 0.
  - Retire pulsed during FETCH -> Pc unchanged.
  - Ack pulsed during HOLD -> Inst unchanged.
- Wrap-around: force Pc=0xFFFF_FFFC, Retire with Pcsrc=00 -> Imem_addr=0x0000_0000.
- Reset mid-operation: Rst asserted in a FETCH wait cycle with Imem_ack=1 that same cycle -> Inst stays 0, Inst_valid=0, Pc=RESET_PC. Rst asserted in HOLD with Retire=1 -> Pc=RESET_PC (not next_pc), then a fresh fetch from RESET_PC.
